// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-table sequencer.
package sccb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START_C,
      BYTE,
      STOP_C,
      GAP,
      FINISH
   } state_e;

   localparam logic [15:0] SCCB_END_ADDR    = 16'hFFFF;
   localparam int          QUARTERS_PER_BIT = 4;
   localparam int          BITS_PER_PHASE   = 9;

endpackage

// File: rtl/sccb_byte_tx.sv
// Shifts one SCCB byte (8 data cells MSB first, then a released don't-care cell) on quarter ticks.
// SIOC is low for quarters 0-1 and high for 2-3 of each cell; byte_done_o fires on the final tick.
module sccb_byte_tx
   import sccb_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick_i,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   output logic       sioc_o,
   output logic       siod_out_o,
   output logic       siod_oe_o,
   output logic       byte_done_o
);

   logic [1:0] qtr_q, qtr_d;
   logic [3:0] cell_q, cell_d;
   logic [7:0] shift_q, shift_d;
   logic       active_q, active_d;
   logic       last_qtr, last_cell;

   assign last_qtr    = (qtr_q == 2'(QUARTERS_PER_BIT - 1));
   assign last_cell   = (cell_q == 4'(BITS_PER_PHASE - 1));
   // Kept independent of load_i so the parent can chain the next load off it.
   assign byte_done_o = active_q && tick_i && last_qtr && last_cell;

   always_comb begin
      qtr_d    = qtr_q;
      cell_d   = cell_q;
      shift_d  = shift_q;
      active_d = active_q;
      if (load_i) begin
         qtr_d    = 2'd0;
         cell_d   = 4'd0;
         shift_d  = byte_i;
         active_d = 1'b1;
      end else if (active_q && tick_i) begin
         qtr_d = qtr_q + 2'd1;
         if (last_qtr) begin
            if (last_cell) begin
               cell_d   = 4'd0;
               active_d = 1'b0;
            end else begin
               cell_d  = cell_q + 4'd1;
               shift_d = {shift_q[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         qtr_q    <= 2'd0;
         cell_q   <= 4'd0;
         shift_q  <= 8'd0;
         active_q <= 1'b0;
      end else begin
         qtr_q    <= qtr_d;
         cell_q   <= cell_d;
         shift_q  <= shift_d;
         active_q <= active_d;
      end
   end

   assign sioc_o     = ~active_q | qtr_q[1];
   assign siod_oe_o  = active_q & ~last_cell;
   assign siod_out_o = last_cell | shift_q[7];

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks a sync-ROM register table and issues one SCCB 3-phase write per entry on SIOC/SIOD.
// Bus pins are registered, so they trail the internal state by one cycle; START is ignored while busy.
module sccb_cfg_seq
   import sccb_pkg::*;
#(
   parameter int          QTR      = 250,
   parameter int          NUM_REGS = 256,
   parameter logic [7:0]  DEV_ID   = 8'h78
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   output logic [7:0]  TBL_ADDR,
   input  logic [23:0] TBL_DATA,
   output logic        SIOC,
   output logic        SIOD_OUT,
   output logic        SIOD_OE,
   output logic        BUSY,
   output logic        DONE,
   output logic [8:0]  REG_CNT
);

   localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

   state_e        state_q, state_d;
   logic          fetch_wait_q, fetch_wait_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [1:0]    phase_q, phase_d;
   logic [23:0]   entry_q, entry_d;
   logic [7:0]    tbl_addr_q, tbl_addr_d;
   logic [8:0]    reg_cnt_q, reg_cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          sioc_q, siod_out_q, siod_oe_q;

   logic          quarter_st, tick;
   logic          tx_load, tx_done, tx_sioc, tx_siod, tx_oe;
   logic [1:0]    load_phase;
   logic          bus_sioc, bus_out, bus_oe;

   function automatic logic [7:0] phase_byte(input logic [1:0] ph, input logic [23:0] ent);
      case (ph)
         2'd0:    return DEV_ID;
         2'd1:    return ent[23:16];
         2'd2:    return ent[15:8];
         default: return ent[7:0];
      endcase
   endfunction

   assign quarter_st = (state_q == START_C) || (state_q == BYTE) ||
                       (state_q == STOP_C)  || (state_q == GAP);
   assign tick       = quarter_st && (qcnt_q == QW'(QTR - 1));
   assign qcnt_d     = (!quarter_st || tick) ? '0 : qcnt_q + 1'b1;

   sccb_byte_tx u_tx (
      .CLK         (CLK),
      .RST         (RST),
      .tick_i      (tick),
      .load_i      (tx_load),
      .byte_i      (phase_byte(load_phase, entry_q)),
      .sioc_o      (tx_sioc),
      .siod_out_o  (tx_siod),
      .siod_oe_o   (tx_oe),
      .byte_done_o (tx_done)
   );

   always_comb begin
      state_d      = state_q;
      fetch_wait_d = fetch_wait_q;
      qtr_d        = qtr_q;
      phase_d      = phase_q;
      entry_d      = entry_q;
      tbl_addr_d   = tbl_addr_q;
      reg_cnt_d    = reg_cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      tx_load      = 1'b0;
      load_phase   = phase_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               tbl_addr_d   = 8'd0;
               reg_cnt_d    = 9'd0;
               busy_d       = 1'b1;
               fetch_wait_d = 1'b0;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            // First cycle lets the ROM see the new address; data is valid on the second.
            if (!fetch_wait_q) begin
               fetch_wait_d = 1'b1;
            end else begin
               fetch_wait_d = 1'b0;
               entry_d      = TBL_DATA;
               qtr_d        = 2'd0;
               state_d      = (TBL_DATA[23:8] == SCCB_END_ADDR) ? FINISH : START_C;
            end
         end
         START_C: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  phase_d    = 2'd0;
                  tx_load    = 1'b1;
                  load_phase = 2'd0;
                  state_d    = BYTE;
               end
            end
         end
         BYTE: begin
            if (tx_done) begin
               if (phase_q == 2'd3) begin
                  qtr_d   = 2'd0;
                  state_d = STOP_C;
               end else begin
                  phase_d    = phase_q + 2'd1;
                  tx_load    = 1'b1;
                  load_phase = phase_q + 2'd1;
               end
            end
         end
         STOP_C: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) state_d = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  reg_cnt_d = reg_cnt_q + 9'd1;
                  if (tbl_addr_q == 8'(NUM_REGS - 1)) begin
                     state_d = FINISH;
                  end else begin
                     tbl_addr_d = tbl_addr_q + 8'd1;
                     state_d    = FETCH;
                  end
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Framing levels per quarter; the byte shifter owns the bus during BYTE.
   always_comb begin
      bus_sioc = 1'b1;
      bus_out  = 1'b1;
      bus_oe   = 1'b0;
      case (state_q)
         START_C: begin
            bus_oe   = 1'b1;
            bus_sioc = ~qtr_q[1];
            bus_out  = (qtr_q == 2'd0);
         end
         BYTE: begin
            bus_sioc = tx_sioc;
            bus_out  = tx_siod;
            bus_oe   = tx_oe;
         end
         STOP_C: begin
            bus_oe   = (qtr_q != 2'd3);
            bus_sioc = (qtr_q != 2'd0);
            bus_out  = qtr_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         fetch_wait_q <= 1'b0;
         qcnt_q       <= '0;
         qtr_q        <= 2'd0;
         phase_q      <= 2'd0;
         entry_q      <= 24'd0;
         tbl_addr_q   <= 8'd0;
         reg_cnt_q    <= 9'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sioc_q       <= 1'b1;
         siod_out_q   <= 1'b1;
         siod_oe_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_wait_q <= fetch_wait_d;
         qcnt_q       <= qcnt_d;
         qtr_q        <= qtr_d;
         phase_q      <= phase_d;
         entry_q      <= entry_d;
         tbl_addr_q   <= tbl_addr_d;
         reg_cnt_q    <= reg_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sioc_q       <= bus_sioc;
         siod_out_q   <= bus_out;
         siod_oe_q    <= bus_oe;
      end
   end

   assign TBL_ADDR = tbl_addr_q;
   assign REG_CNT  = reg_cnt_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign SIOC     = sioc_q;
   assign SIOD_OUT = siod_out_q;
   assign SIOD_OE  = siod_oe_q;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Table-driven bench for sccb_cfg_seq with an SCCB slave model decoding start, bytes and stop.
module tb_sccb_cfg_seq;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [7:0]  TBL_ADDR;
   logic [23:0] TBL_DATA;
   logic        SIOC, SIOD_OUT, SIOD_OE, BUSY, DONE;
   logic [8:0]  REG_CNT;

   sccb_cfg_seq #(.QTR(2), .NUM_REGS(4), .DEV_ID(8'h78)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .TBL_ADDR (TBL_ADDR),
      .TBL_DATA (TBL_DATA),
      .SIOC     (SIOC),
      .SIOD_OUT (SIOD_OUT),
      .SIOD_OE  (SIOD_OE),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .REG_CNT  (REG_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   logic [3:0][23:0] rom;
   always @(posedge CLK) TBL_DATA <= rom[TBL_ADDR[1:0]];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave model / bus monitor: sole writer of its statistics.
   logic        mon_clr = 1'b0;
   logic        ack_val = 1'b0;
   logic        prev_sioc = 1'b1, prev_siod = 1'b1, sc, sd;
   logic        in_frame = 1'b0, ack_drv = 1'b0;
   int          bitcnt = 0, bytecnt = 0, nwr = 0, starts = 0, stops = 0, ack_oe_bad = 0;
   logic [7:0]  sh = 8'd0;
   logic [7:0]  bbuf [4];
   logic [31:0] wlog [16];

   initial forever begin
      @(negedge CLK);
      if (mon_clr) begin
         starts = 0; stops = 0; nwr = 0; ack_oe_bad = 0;
         in_frame = 1'b0; bitcnt = 0; bytecnt = 0; ack_drv = 1'b0;
      end
      sc = SIOC;
      if (prev_sioc && !sc) begin
         ack_drv = (bitcnt == 8);
         if (ack_drv && SIOD_OE) ack_oe_bad++;
      end
      sd = SIOD_OE ? SIOD_OUT : (ack_drv ? ack_val : 1'b1);
      if (prev_sioc && sc && (sd != prev_siod)) begin
         if (!sd) begin
            starts++; in_frame = 1'b1; bitcnt = 0; bytecnt = 0;
         end else begin
            stops++;
            if (in_frame && bytecnt == 4) begin
               if (nwr < 16) wlog[nwr] = {bbuf[0], bbuf[1], bbuf[2], bbuf[3]};
               nwr++;
            end
            in_frame = 1'b0;
         end
      end else if (!prev_sioc && sc && in_frame && bytecnt < 4) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], sd};
            bitcnt++;
         end else begin
            if (SIOD_OE) ack_oe_bad++;
            bbuf[bytecnt] = sh;
            bytecnt++;
            bitcnt = 0;
         end
      end
      prev_sioc = sc;
      prev_siod = sd;
   end

   typedef struct packed {
      logic [3:0][23:0] tbl;
      logic             ack;
      logic             mid;
      logic [3:0]       nwr;
      logic [8:0]       regcnt;
      logic [7:0]       taddr;
      logic [15:0]      cycles;
   } vec_t;

   vec_t vecs [4];

   task automatic clear_monitor();
      mon_clr = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      mon_clr = 1'b0;
   endtask

   task automatic run_scn(input vec_t v, input string tag);
      int   t0;
      logic prev_busy;
      rom     = v.tbl;
      ack_val = v.ack;
      clear_monitor();
      START = 1'b1;
      t0    = cyc;
      @(negedge CLK);
      START = 1'b0;
      chk({tag, " busy_after_start"}, BUSY, 1'b1);
      prev_busy = BUSY;
      while (!DONE && (cyc - t0) < 3000) begin
         prev_busy = BUSY;
         START = v.mid && ((cyc - t0) == 180);
         @(negedge CLK);
      end
      START = 1'b0;
      chk({tag, " done_seen"}, DONE, 1'b1);
      chk({tag, " start_to_done"}, 32'(cyc - t0), 32'(v.cycles));
      chk({tag, " busy_low_at_done"}, BUSY, 1'b0);
      chk({tag, " busy_high_before_done"}, prev_busy, 1'b1);
      chk({tag, " reg_cnt"}, REG_CNT, 32'(v.regcnt));
      chk({tag, " tbl_addr"}, TBL_ADDR, 32'(v.taddr));
      @(negedge CLK);
      chk({tag, " done_one_cycle"}, DONE, 1'b0);
      repeat (6) @(negedge CLK);
      chk({tag, " writes"}, 32'(nwr), 32'(v.nwr));
      chk({tag, " starts"}, 32'(starts), 32'(v.nwr));
      chk({tag, " stops"}, 32'(stops), 32'(v.nwr));
      chk({tag, " ack_cell_released"}, 32'(ack_oe_bad), 32'd0);
      for (int w = 0; w < 4; w++)
         if (w < int'(v.nwr)) chk({tag, $sformatf(" write%0d", w)}, wlog[w], {8'h78, v.tbl[w]});
   endtask

   initial begin
      logic [3:0][23:0] norm, mark1, mark0;
      int t0;
      norm  = {24'h503D00, 24'h430030, 24'h310303, 24'h300882};
      mark1 = {24'h503D00, 24'h430030, 24'hFFFF5A, 24'h300882};
      mark0 = {24'h503D00, 24'h430030, 24'h310303, 24'hFFFF00};
      // One write = 156 quarters * 2 cycles + 2 fetch cycles = 314.
      vecs[0] = '{tbl: norm,  ack: 1'b0, mid: 1'b0, nwr: 4'd4, regcnt: 9'd4, taddr: 8'd3, cycles: 16'd1258};
      vecs[1] = '{tbl: mark1, ack: 1'b1, mid: 1'b0, nwr: 4'd1, regcnt: 9'd1, taddr: 8'd1, cycles: 16'd318};
      vecs[2] = '{tbl: norm,  ack: 1'b1, mid: 1'b1, nwr: 4'd4, regcnt: 9'd4, taddr: 8'd3, cycles: 16'd1258};
      vecs[3] = '{tbl: mark0, ack: 1'b0, mid: 1'b0, nwr: 4'd0, regcnt: 9'd0, taddr: 8'd0, cycles: 16'd4};

      rom   = norm;
      RST   = 1'b1;
      START = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("reset SIOC", SIOC, 1'b1);
      chk("reset SIOD_OUT", SIOD_OUT, 1'b1);
      chk("reset SIOD_OE", SIOD_OE, 1'b0);
      chk("reset BUSY", BUSY, 1'b0);
      chk("reset DONE", DONE, 1'b0);
      chk("reset TBL_ADDR", TBL_ADDR, 8'd0);
      chk("reset REG_CNT", REG_CNT, 9'd0);

      for (int i = 0; i < 4; i++) run_scn(vecs[i], $sformatf("vec%0d", i));

      // Reset during the data byte of entry 1, then a clean restart from entry 0.
      rom     = norm;
      ack_val = 1'b0;
      clear_monitor();
      START = 1'b1;
      t0    = cyc;
      @(negedge CLK);
      START = 1'b0;
      while ((cyc - t0) < 558) @(negedge CLK);
      chk("pre_reset REG_CNT", REG_CNT, 9'd1);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst SIOC", SIOC, 1'b1);
      chk("midrst SIOD_OE", SIOD_OE, 1'b0);
      chk("midrst BUSY", BUSY, 1'b0);
      chk("midrst DONE", DONE, 1'b0);
      chk("midrst REG_CNT", REG_CNT, 9'd0);
      chk("midrst TBL_ADDR", TBL_ADDR, 8'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      run_scn(vecs[0], "restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
